serial_addsub: RTL and testbench



---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_digit.sv | 33 +++
 rtl/serial_addsub.sv | 125 ++++++++++++
 tb/tb_serial_addsub.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and mode constants for serial_addsub
//   state_t  : IDLE / RUN / DONE control states
//   MODE_*   : in_sub encodings
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-bit ripple-carry slice
//   a, b  in  DIGIT  operand digits
//   cin   in  1      carry into bit 0
//   sum   out DIGIT  digit sum
//   cout  out 1      carry out of the MSB
//   cmsb  out 1      carry into the MSB (overflow detection)
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor with valid/ready handshakes
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   in_a, in_b          operands; in_sub selects a-b-cin, in_cin carry/borrow-in
//   out_valid/out_ready result handshake (valid only in DONE)
//   out_s               result; out_cout carry (sub: 1 = no borrow)
//   out_ovf, out_zero   signed overflow, result-is-zero
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_r, b_r, acc_r, acc_nxt;
  logic             carry;
  logic             last;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout, slice_cmsb;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_r[DIGIT-1:0]),
    .b    (b_r[DIGIT-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  // Each new digit enters at the MSB end so after N shifts the LSB digit
  // has walked down to bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_full
      assign acc_nxt = slice_sum;
    end else begin : g_shift
      assign acc_nxt = {slice_sum, acc_r[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last = (count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~cin, so a borrow-in becomes a missing carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      out_s    <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= (in_sub == MODE_SUB) ? ~in_b : in_b;
            carry <= (in_sub == MODE_SUB) ? ~in_cin : in_cin;
            count <= '0;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          acc_r <= acc_nxt;
          carry <= slice_cout;
          if (last) begin
            out_s    <= acc_nxt;
            out_cout <= slice_cout;
            out_ovf  <= slice_cmsb ^ slice_cout;
            out_zero <= (acc_nxt == '0);
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (DIGIT 4, 16, 1)
module tb_serial_addsub;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] in_a      [3];
  logic [15:0] in_b      [3];
  logic        in_sub    [3];
  logic        in_cin    [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] out_s     [3];
  logic        out_cout  [3];
  logic        out_ovf   [3];
  logic        out_zero  [3];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic        tmo_pending = 1'b0;
  logic        lit_armed   = 1'b0;
  logic [15:0] lit_s;
  logic        lit_cout, lit_ovf, lit_zero;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int DG = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
      serial_addsub #(.WIDTH(16), .DIGIT(DG)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_a      (in_a[g]),
        .in_b      (in_b[g]),
        .in_sub    (in_sub[g]),
        .in_cin    (in_cin[g]),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_s     (out_s[g]),
        .out_cout  (out_cout[g]),
        .out_ovf   (out_ovf[g]),
        .out_zero  (out_zero[g])
      );
    end
  endgenerate

  function automatic int nof(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
  endfunction

  // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
    exp_t e;
    int ua, ub, sa, sb, ci, ur, r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(cin);
    if (sub) begin
      ur     = ua - ub - ci;
      r      = sa - sb - ci;
      e.cout = (ur >= 0);
    end else begin
      ur     = ua + ub + ci;
      r      = sa + sb + ci;
      e.cout = (ur > 65535);
    end
    e.s    = ur[15:0];
    e.ovf  = (r > 32767) || (r < -32768);
    e.zero = (e.s == 16'h0000);
    e.acc  = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d cyc%0d: got 0x%0h, required 0x%0h", nm, k, cyc, act, exp);
    end
  endtask

  // Compare process: every negedge, all three instances.
  initial begin : compare
    exp_t pend    [3];
    logic pend_v  [3];
    logic ov_prev [3];
    logic rst_prev;
    logic pinned;
    exp_t m;
    rst_prev = 1'b0;
    pinned   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pend_v[k]  = 1'b0;
      ov_prev[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!pinned) begin
        m = model(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        chk("pin add s", 0, 32'(m.s), 32'h2233);
        m = model(16'h0005, 16'h0007, 1'b1, 1'b0);
        chk("pin sub s", 0, 32'(m.s), 32'hFFFE);
        chk("pin sub cout", 0, 32'(m.cout), 32'h0);
        m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("pin add ovf", 0, 32'(m.ovf), 32'h1);
        m = model(16'h8000, 16'h0001, 1'b1, 1'b0);
        chk("pin sub ovf", 0, 32'({m.s, m.cout, m.ovf}), 32'({16'h7FFF, 1'b1, 1'b1}));
        pinned = 1'b1;
      end
      if (tmo_pending) begin
        nvec++;
        nerr++;
        $display("FAIL timeout waiting on DUT handshake at cyc%0d", cyc);
        tmo_pending = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (rst_prev) begin
          chk("reset in_ready", k, 32'(in_ready[k]), 32'h1);
          chk("reset out_valid", k, 32'(out_valid[k]), 32'h0);
          chk("reset out_s", k, 32'(out_s[k]), 32'h0);
          chk("reset flags", k, 32'({out_cout[k], out_ovf[k], out_zero[k]}), 32'h0);
        end
        if (rst) begin
          pend_v[k]  = 1'b0;
          ov_prev[k] = 1'b0;
        end else begin
          chk("in_ready", k, 32'(in_ready[k]), 32'(!pend_v[k]));
          if (out_valid[k]) begin
            if (!pend_v[k]) begin
              chk("unexpected out_valid", k, 32'(out_valid[k]), 32'h0);
            end else begin
              if (!ov_prev[k])
                chk("latency", k, 32'(cyc), 32'(pend[k].acc + 1 + nof(k)));
              chk("out_s", k, 32'(out_s[k]), 32'(pend[k].s));
              chk("out_cout", k, 32'(out_cout[k]), 32'(pend[k].cout));
              chk("out_ovf", k, 32'(out_ovf[k]), 32'(pend[k].ovf));
              chk("out_zero", k, 32'(out_zero[k]), 32'(pend[k].zero));
              if (k == 0 && lit_armed) begin
                chk("lit out_s", k, 32'(out_s[k]), 32'(lit_s));
                chk("lit flags", k, 32'({out_cout[k], out_ovf[k], out_zero[k]}),
                    32'({lit_cout, lit_ovf, lit_zero}));
              end
              if (out_ready[k]) pend_v[k] = 1'b0;
            end
          end else if (pend_v[k] && cyc >= pend[k].acc + 1 + nof(k)) begin
            chk("out_valid rise", k, 32'(out_valid[k]), 32'h1);
            pend_v[k] = 1'b0;
          end
          if (in_valid[k] && in_ready[k]) begin
            pend[k]     = model(in_a[k], in_b[k], in_sub[k], in_cin[k]);
            pend[k].acc = cyc;
            pend_v[k]   = 1'b1;
          end
          ov_prev[k] = out_valid[k];
        end
      end
      rst_prev = rst;
    end
  end

  task automatic wait_sig(input int k, input bit want_out);
    int g;
    g = 0;
    forever begin
      @(negedge clk);
      if (want_out ? out_valid[k] : in_ready[k]) break;
      g++;
      if (g > 100) begin
        tmo_pending = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_in(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin);
    in_a[k]   = a;
    in_b[k]   = b;
    in_sub[k] = sub;
    in_cin[k] = cin;
  endtask

  task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic sub,
                     input logic cin, input logic [15:0] es, input logic ec,
                     input logic eo, input logic ez, input bit stall);
    set_in(0, a, b, sub, cin);
    lit_s = es; lit_cout = ec; lit_ovf = eo; lit_zero = ez;
    lit_armed   = 1'b1;
    in_valid[0] = 1'b1;
    wait_sig(0, 1'b0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_sig(0, 1'b1);
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (i == 1) begin
          set_in(0, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
          in_valid[0] = 1'b1;
        end else begin
          in_valid[0] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    lit_armed    = 1'b0;
  endtask

  task automatic rand_in(input int k);
    logic [15:0] corner [4];
    corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    in_a[k]   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
    in_b[k]   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
    in_sub[k] = 1'($urandom_range(0, 1));
    in_cin[k] = 1'($urandom_range(0, 1));
  endtask

  initial begin : stim
    int  ops [3];
    logic acc [3];
    int  guard;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      set_in(k, 16'h0, 16'h0, 1'b0, 1'b0);
      ops[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    op0(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
    op0(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    op0(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    op0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    op0(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    op0(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort on the second RUN edge.
    set_in(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    in_valid[0] = 1'b1;
    wait_sig(0, 1'b0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Random back-to-back traffic on all three widths.
    for (int k = 0; k < 3; k++) begin
      rand_in(k);
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b1;
    end
    guard = 0;
    while ((ops[0] < 200 || ops[1] < 200 || ops[2] < 200) && guard < 20000) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) acc[k] = in_valid[k] && in_ready[k];
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) begin
          ops[k]++;
          if (ops[k] < 200) rand_in(k);
          else in_valid[k] = 1'b0;
        end
        out_ready[k] = ($urandom_range(0, 7) != 0);
      end
      guard++;
    end
    if (guard >= 20000) tmo_pending = 1'b1;
    for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
